// File: rtl/cascade_counter.sv
// cascade_counter
//
// Multi-stage cascaded counter used as a general timebase / event counter.
// NUM_STAGES digit stages of STAGE_WIDTH bits each count modulo STAGE_MODULO;
// stage i steps only when every lower stage rolls over in the same direction.
// Supports up/down counting, synchronous clear and load (with per-field
// clamping), a one-cycle wrap pulse, a sticky overflow flag and a
// combinational compare match.
//
// Ports:
//   clock           rising-edge clock
//   reset           asynchronous active-low reset
//   enable          count-advance request for this cycle
//   up_down         1 = count up, 0 = count down
//   clear           synchronous clear of count and overflow
//   load            synchronous load of load_value (clamped per stage)
//   load_value      packed per-stage load fields, stage i at [i*W +: W]
//   overflow_clear  clears the sticky overflow flag (a same-edge wrap wins)
//   compare_value   packed match target
//   count           registered packed stage values
//   carry_out       registered one-cycle pulse following a full wrap
//   overflow        sticky wrap flag
//   match           count == compare_value (combinational)

module cascade_counter #(
    parameter int NUM_STAGES   = 2,
    parameter int STAGE_WIDTH  = 5,
    parameter int STAGE_MODULO = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              up_down,
    input  logic                              clear,
    input  logic                              load,
    input  logic [NUM_STAGES*STAGE_WIDTH-1:0] load_value,
    input  logic                              overflow_clear,
    input  logic [NUM_STAGES*STAGE_WIDTH-1:0] compare_value,
    output logic [NUM_STAGES*STAGE_WIDTH-1:0] count,
    output logic                              carry_out,
    output logic                              overflow,
    output logic                              match
);

    // Largest legal digit value. Rollover is detected against this value so a
    // modulus below 2^STAGE_WIDTH wraps correctly instead of relying on the
    // natural binary overflow of the stage register.
    localparam logic [STAGE_WIDTH-1:0] STAGE_MAX = STAGE_WIDTH'(STAGE_MODULO - 1);

    logic [NUM_STAGES-1:0][STAGE_WIDTH-1:0] count_q, count_d;
    logic                                   carry_q, carry_d;
    logic                                   overflow_q, overflow_d;

    logic [NUM_STAGES-1:0][STAGE_WIDTH-1:0] load_fields;

    // lower_max[i] / lower_zero[i]: every stage below i sits at its up / down
    // rollover point. Index NUM_STAGES therefore means "the whole counter".
    logic [NUM_STAGES:0] lower_max;
    logic [NUM_STAGES:0] lower_zero;
    logic                full_wrap;

    assign load_fields = load_value;

    always_comb begin
        lower_max[0]  = 1'b1;
        lower_zero[0] = 1'b1;
        for (int i = 0; i < NUM_STAGES; i++) begin
            lower_max[i+1]  = lower_max[i]  && (count_q[i] == STAGE_MAX);
            lower_zero[i+1] = lower_zero[i] && (count_q[i] == '0);
        end
    end

    assign full_wrap = enable && (up_down ? lower_max[NUM_STAGES] : lower_zero[NUM_STAGES]);

    always_comb begin
        // NOTE: every signal written here gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        count_d    = count_q;
        carry_d    = 1'b0;
        overflow_d = overflow_q;

        if (clear) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (load) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                count_d[i] = (load_fields[i] > STAGE_MAX) ? STAGE_MAX : load_fields[i];
            end
            if (overflow_clear) begin
                overflow_d = 1'b0;
            end
        end else begin
            if (enable) begin
                for (int i = 0; i < NUM_STAGES; i++) begin
                    if (up_down && lower_max[i]) begin
                        count_d[i] = (count_q[i] == STAGE_MAX) ? '0 : count_q[i] + 1'b1;
                    end else if (!up_down && lower_zero[i]) begin
                        count_d[i] = (count_q[i] == '0) ? STAGE_MAX : count_q[i] - 1'b1;
                    end
                end
            end
            // A wrap on the same edge takes precedence over overflow_clear.
            if (full_wrap) begin
                carry_d    = 1'b1;
                overflow_d = 1'b1;
            end else if (overflow_clear) begin
                overflow_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
        end
    end

    assign count     = count_q;
    assign carry_out = carry_q;
    assign overflow  = overflow_q;
    assign match     = (count_q == compare_value);

endmodule

// File: tb/tb_cascade_counter.sv
// Directed bench for cascade_counter. Two instances share clock and reset:
// u_def uses default parameters (2 x 5-bit, modulo 32); u_m10 is a 2 x 4-bit
// decimal counter (modulo 10) for the non-power-of-two and clamp cases.

module tb_cascade_counter;

    logic clock = 1'b0;
    logic reset = 1'b0;

    // default instance signals
    logic        d_en = 0, d_ud = 1, d_clr = 0, d_ld = 0, d_oc = 0;
    logic [9:0]  d_lv = '0, d_cv = '0;
    logic [9:0]  d_cnt;
    logic        d_co, d_ov, d_m;

    // modulo-10 instance signals
    logic        m_en = 0, m_ud = 1, m_clr = 0, m_ld = 0, m_oc = 0;
    logic [7:0]  m_lv = '0, m_cv = '0;
    logic [7:0]  m_cnt;
    logic        m_co, m_ov, m_m;

    int checks = 0;
    int errors = 0;

    cascade_counter u_def (
        .clock(clock), .reset(reset), .enable(d_en), .up_down(d_ud),
        .clear(d_clr), .load(d_ld), .load_value(d_lv), .overflow_clear(d_oc),
        .compare_value(d_cv), .count(d_cnt), .carry_out(d_co),
        .overflow(d_ov), .match(d_m)
    );

    cascade_counter #(.NUM_STAGES(2), .STAGE_WIDTH(4), .STAGE_MODULO(10)) u_m10 (
        .clock(clock), .reset(reset), .enable(m_en), .up_down(m_ud),
        .clear(m_clr), .load(m_ld), .load_value(m_lv), .overflow_clear(m_oc),
        .compare_value(m_cv), .count(m_cnt), .carry_out(m_co),
        .overflow(m_ov), .match(m_m)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // ---- reset state (match compares count 0 against compare_value 0)
        #2;
        check("rst_cnt", 32'(d_cnt), 32'h0);
        check("rst_co",  32'(d_co),  32'h0);
        check("rst_ov",  32'(d_ov),  32'h0);
        check("rst_match", 32'(d_m), 32'h1);

        // ---- count to 0x2A, then asynchronous reset between edges
        #10;                 // t=12, between edges
        reset = 1'b1;
        d_en  = 1'b1;
        repeat (42) step();
        check("cnt_2a", 32'(d_cnt), 32'h2A);
        #2;
        reset = 1'b0;
        #1;                  // still before the next edge
        check("async_rst_cnt", 32'(d_cnt), 32'h0);
        check("async_rst_co",  32'(d_co),  32'h0);
        check("async_rst_ov",  32'(d_ov),  32'h0);
        repeat (2) step();
        check("rst_hold_cnt", 32'(d_cnt), 32'h0);
        reset = 1'b1;        // released 1 unit after an edge

        // ---- up count, first stage-1 increment after 32 cycles
        repeat (32) step();
        check("up32_cnt", 32'(d_cnt), {22'h0, 5'd1, 5'd0});
        repeat (991) step();
        check("up1023_cnt", 32'(d_cnt), 32'h3FF);
        check("up1023_co",  32'(d_co),  32'h0);
        check("up1023_ov",  32'(d_ov),  32'h0);
        step();
        check("wrap_cnt", 32'(d_cnt), 32'h0);
        check("wrap_co",  32'(d_co),  32'h1);
        check("wrap_ov",  32'(d_ov),  32'h1);
        d_en = 1'b0;
        step();
        check("post_wrap_co",  32'(d_co),  32'h0);
        check("post_wrap_cnt", 32'(d_cnt), 32'h0);
        check("post_wrap_ov",  32'(d_ov),  32'h1);

        // ---- priority: clear beats load and enable
        d_clr = 1'b1; d_ld = 1'b1; d_en = 1'b1; d_lv = {5'd3, 5'd4};
        step();
        check("clr_pri_cnt", 32'(d_cnt), 32'h0);
        check("clr_pri_ov",  32'(d_ov),  32'h0);
        d_clr = 1'b0;        // load still beats enable
        step();
        check("ld_pri_cnt", 32'(d_cnt), {22'h0, 5'd3, 5'd4});
        check("ld_pri_co",  32'(d_co),  32'h0);
        d_ld = 1'b0; d_en = 1'b0;

        // ---- modulo 10, down from 0: full wrap to 99
        m_en = 1'b1; m_ud = 1'b0; m_oc = 1'b1;   // overflow_clear loses to wrap
        step();
        check("m10_down_cnt", 32'(m_cnt), 32'h99);
        check("m10_down_co",  32'(m_co),  32'h1);
        check("m10_down_ov",  32'(m_ov),  32'h1);
        m_oc = 1'b0;
        step();
        check("m10_down2_cnt", 32'(m_cnt), 32'h98);
        check("m10_down2_co",  32'(m_co),  32'h0);
        check("m10_down2_ov",  32'(m_ov),  32'h1);
        m_en = 1'b0; m_oc = 1'b1;
        step();
        check("m10_oc_ov", 32'(m_ov), 32'h0);
        m_oc = 1'b0;

        // ---- clamp: stage0 field 12 -> 9, stage1 field 5 kept
        m_ld = 1'b1; m_lv = {4'd5, 4'd12};
        step();
        check("clamp_cnt", 32'(m_cnt), 32'h59);
        check("clamp_ov",  32'(m_ov),  32'h0);
        m_ld = 1'b0; m_en = 1'b1; m_ud = 1'b1;
        step();
        check("clamp_up_cnt", 32'(m_cnt), 32'h60);
        check("clamp_up_co",  32'(m_co),  32'h0);

        // ---- decimal rollover of stage 0 at 9, not at 15
        m_en = 1'b0; m_ld = 1'b1; m_lv = 8'h39;
        step();
        m_ld = 1'b0; m_en = 1'b1;
        step();
        check("m10_roll_cnt", 32'(m_cnt), 32'h40);

        // ---- compare match against {0,3}
        m_en = 1'b0; m_cv = 8'h03; m_ld = 1'b1; m_lv = 8'h02;
        step();
        check("match_02", 32'(m_m), 32'h0);
        m_ld = 1'b0; m_en = 1'b1;
        step();
        check("match_03", 32'(m_m), 32'h1);
        step();
        check("match_04_cnt", 32'(m_cnt), 32'h04);
        check("match_04", 32'(m_m), 32'h0);
        m_ud = 1'b0;         // direction change takes effect on next edge
        step();
        check("match_back_03", 32'(m_m), 32'h1);
        m_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
